tset_ctrl: RTL and testbench

- Time-set sequencer for the world-clock display; button-driven controller that configures the main time counter.
- Takes debounced single-cycle button pulses, walks the user through editing hour, minute and second, then issues a one-cycle load strobe with the new value.
- Sits between the button debouncers and the time-keeping counter, alongside the mode/time-zone select logic; provides the field-blink control to the display mux.

---
 rtl/tset_pkg.sv | 36 +++
 rtl/tset_wrap_ctr.sv | 31 +++
 rtl/tset_ctrl.sv | 149 ++++++++++++++
 tb/tb_tset_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tset_pkg.sv
// Shared types and constants for the time-set sequencer (tset_ctrl).
package tset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOUR   = 3'd1,
    ST_MIN    = 3'd2,
    ST_SEC    = 3'd3,
    ST_COMMIT = 3'd4
  } tset_state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  // Field code shown to the display mux for a given state.
  function automatic logic [1:0] field_of(input tset_state_t s);
    case (s)
      ST_HOUR: return FIELD_HOUR;
      ST_MIN:  return FIELD_MIN;
      ST_SEC:  return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

  // True in the states where the user is editing a field.
  function automatic logic is_edit(input tset_state_t s);
    return (s == ST_HOUR) || (s == ST_MIN) || (s == ST_SEC);
  endfunction

endpackage

// File: rtl/tset_wrap_ctr.sv
// Modular up/down counter for one time field (0..MAX) with parallel load.
// Load has priority; inc and dec together cancel and leave the value alone.
module tset_wrap_ctr import tset_pkg::*; #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] VMAX = W'(MAX);

  // Field value register: load, wrap-around increment, wrap-around decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc && !dec) begin
      value <= (value == VMAX) ? '0 : value + W'(1);
    end else if (dec && !inc) begin
      value <= (value == '0) ? VMAX : value - W'(1);
    end
  end

endmodule

// File: rtl/tset_ctrl.sv
// Time-set sequencer: walks the user through hour/minute/second editing from
// debounced button pulses and emits a one-cycle load strobe with the result.
// Optional build macro TSET_SEC_ZERO_EN: skip the seconds field and commit
// with seconds forced to zero.
module tset_ctrl import tset_pkg::*; #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_p,
  input  logic       inc_p,
  input  logic       dec_p,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       edit_active,
  output logic [1:0] edit_field,
  output logic [4:0] edit_hour,
  output logic [5:0] edit_min,
  output logic [5:0] edit_sec,
  output logic       load_p,
  output logic       blink_on
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);

  tset_state_t state, state_next;

  logic [TW-1:0] to_cnt, to_cnt_next;
  logic [BW-1:0] bl_cnt, bl_cnt_next;
  logic          blink_next;

  logic       any_pulse, to_hit, capture, sec_zero, adj_ok, field_entry;
  logic       hour_inc, hour_dec, min_inc, min_dec, sec_inc, sec_dec;
  logic       sec_load;
  logic [5:0] sec_load_val;

  // Next-state, field-counter controls, idle timer and blink generator.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    sec_zero     = 1'b0;
    any_pulse    = set_p | inc_p | dec_p;
    to_hit       = (to_cnt == TO_LAST) && !any_pulse;

    case (state)
      ST_IDLE: begin
        if (set_p) begin
          state_next = ST_HOUR;
          capture    = 1'b1;
        end
      end
      ST_HOUR: begin
        if (set_p)       state_next = ST_MIN;
        else if (to_hit) state_next = ST_IDLE;
      end
      ST_MIN: begin
        if (set_p) begin
`ifdef TSET_SEC_ZERO_EN
          state_next = ST_COMMIT;
          sec_zero   = 1'b1;
`else
          state_next = ST_SEC;
`endif
        end else if (to_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_SEC: begin
        if (set_p)       state_next = ST_COMMIT;
        else if (to_hit) state_next = ST_IDLE;
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    // set_p wins over a simultaneous inc/dec, so adjustment needs set_p low.
    adj_ok   = is_edit(state) && !set_p;
    hour_inc = adj_ok && (state == ST_HOUR) && inc_p;
    hour_dec = adj_ok && (state == ST_HOUR) && dec_p;
    min_inc  = adj_ok && (state == ST_MIN)  && inc_p;
    min_dec  = adj_ok && (state == ST_MIN)  && dec_p;
    sec_inc  = adj_ok && (state == ST_SEC)  && inc_p;
    sec_dec  = adj_ok && (state == ST_SEC)  && dec_p;

    sec_load     = capture | sec_zero;
    sec_load_val = sec_zero ? 6'd0 : cur_sec;

    field_entry = is_edit(state_next) && (state_next != state);

    if (!is_edit(state_next) || field_entry || any_pulse) begin
      to_cnt_next = '0;
    end else begin
      to_cnt_next = to_cnt + TW'(1);
    end

    if (!is_edit(state_next) || field_entry || inc_p || dec_p) begin
      blink_next  = 1'b1;
      bl_cnt_next = '0;
    end else if (bl_cnt == BL_LAST) begin
      blink_next  = ~blink_on;
      bl_cnt_next = '0;
    end else begin
      blink_next  = blink_on;
      bl_cnt_next = bl_cnt + BW'(1);
    end
  end

  // State, timers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      bl_cnt      <= '0;
      blink_on    <= 1'b1;
      edit_active <= 1'b0;
      edit_field  <= FIELD_NONE;
      load_p      <= 1'b0;
    end else begin
      state       <= state_next;
      to_cnt      <= to_cnt_next;
      bl_cnt      <= bl_cnt_next;
      blink_on    <= blink_next;
      edit_active <= is_edit(state_next);
      edit_field  <= field_of(state_next);
      load_p      <= (state_next == ST_COMMIT);
    end
  end

  tset_wrap_ctr #(.W(5), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst_n(rst_n), .load(capture), .load_val(cur_hour),
    .inc(hour_inc), .dec(hour_dec), .value(edit_hour)
  );

  tset_wrap_ctr #(.W(6), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst_n(rst_n), .load(capture), .load_val(cur_min),
    .inc(min_inc), .dec(min_dec), .value(edit_min)
  );

  tset_wrap_ctr #(.W(6), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst_n(rst_n), .load(sec_load), .load_val(sec_load_val),
    .inc(sec_inc), .dec(sec_dec), .value(edit_sec)
  );

endmodule

// File: tb/tb_tset_ctrl.sv
// Directed testbench for tset_ctrl with a load-strobe scoreboard.
module tb_tset_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       set_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       edit_active, load_p, blink_on;
  logic [1:0] edit_field;
  logic [4:0] edit_hour;
  logic [5:0] edit_min, edit_sec;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int h;
    int m;
    int s;
  } exp_t;
  exp_t sb_q[$];

  tset_ctrl #(.TIMEOUT_CYC(100), .BLINK_HALF(4)) dut (
    .clk(clk), .rst_n(rst_n), .set_p(set_p), .inc_p(inc_p), .dec_p(dec_p),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .edit_active(edit_active), .edit_field(edit_field),
    .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
    .load_p(load_p), .blink_on(blink_on)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses, return #1 after the sampling edge.
  task automatic applyStimulus(input logic s, input logic i, input logic d);
    set_p = s; inc_p = i; dec_p = d;
    @(posedge clk); #1;
    set_p = 1'b0; inc_p = 1'b0; dec_p = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard side: every load strobe must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_p) begin
        checkOutput("load_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("load_hour", edit_hour, e.h);
          checkOutput("load_min",  edit_min,  e.m);
          checkOutput("load_sec",  edit_sec,  e.s);
        end
      end
`ifdef TSET_SEC_ZERO_EN
      checkOutput("field_never_3", edit_field == 2'd3, 0);
`endif
    end
  end

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_active", edit_active, 0);
    checkOutput("rst_field",  edit_field, 0);
    checkOutput("rst_hour",   edit_hour, 0);
    checkOutput("rst_load",   load_p, 0);
    checkOutput("rst_blink",  blink_on, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idleCycles(1);

    // Basic edit: 13:45:30 -> 15:45:30 (15:45:00 with seconds skipped)
    cur_hour = 5'd13; cur_min = 6'd45; cur_sec = 6'd30;
    applyStimulus(0, 1, 0);
    checkOutput("idle_inc_ignored_act",  edit_active, 0);
    checkOutput("idle_inc_ignored_hour", edit_hour, 0);
    applyStimulus(1, 0, 0);
    checkOutput("t1_active", edit_active, 1);
    checkOutput("t1_field_hour", edit_field, 1);
    checkOutput("t1_capture_hour", edit_hour, 13);
    checkOutput("t1_capture_sec", edit_sec, 30);
    checkOutput("t1_blink", blink_on, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t1_hour_15", edit_hour, 15);
    applyStimulus(1, 0, 0);
    checkOutput("t1_field_min", edit_field, 2);
`ifdef TSET_SEC_ZERO_EN
    sb_q.push_back('{15, 45, 0});
`else
    applyStimulus(1, 0, 0);
    checkOutput("t1_field_sec", edit_field, 3);
    sb_q.push_back('{15, 45, 30});
`endif
    applyStimulus(1, 0, 0);
    checkOutput("t1_load", load_p, 1);
    checkOutput("t1_commit_field", edit_field, 0);
    checkOutput("t1_commit_active", edit_active, 0);
    idleCycles(1);
    checkOutput("t1_load_one_cycle", load_p, 0);
    checkOutput("t1_idle_field", edit_field, 0);
    checkOutput("t1_hold_hour", edit_hour, 15);

    // Wrap boundaries and blink
    cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd59;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t2_hour_wrap", edit_hour, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("t2_min_wrap", edit_min, 59);
    idleCycles(3);
    checkOutput("t2_blink_still_on", blink_on, 1);
    idleCycles(1);
    checkOutput("t2_blink_off", blink_on, 0);
    idleCycles(4);
    checkOutput("t2_blink_on_again", blink_on, 1);
`ifdef TSET_SEC_ZERO_EN
    sb_q.push_back('{0, 59, 0});
`else
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t2_sec_wrap", edit_sec, 0);
    sb_q.push_back('{0, 59, 0});
`endif
    applyStimulus(1, 0, 0);
    checkOutput("t2_load", load_p, 1);
    idleCycles(1);

    // Timeout without pulses, then with one pulse at cycle 90
    cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    applyStimulus(1, 0, 0);
    idleCycles(99);
    checkOutput("t3_before_timeout", edit_active, 1);
    idleCycles(1);
    checkOutput("t3_timeout_active", edit_active, 0);
    checkOutput("t3_timeout_field", edit_field, 0);
    applyStimulus(1, 0, 0);
    idleCycles(89);
    applyStimulus(0, 1, 0);
    checkOutput("t3_inc_hour", edit_hour, 2);
    idleCycles(99);
    checkOutput("t3_delayed_active", edit_active, 1);
    idleCycles(1);
    checkOutput("t3_delayed_exit", edit_active, 0);

    // Simultaneous pulses
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 1);
    checkOutput("t4_incdec_hour", edit_hour, 10);
    applyStimulus(1, 1, 0);
    checkOutput("t4_setinc_field", edit_field, 2);
    checkOutput("t4_setinc_hour", edit_hour, 10);
    checkOutput("t4_setinc_min", edit_min, 20);

    // Asynchronous reset in the middle of minute editing
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_active", edit_active, 0);
    checkOutput("t5_rst_field", edit_field, 0);
    checkOutput("t5_rst_hour", edit_hour, 0);
    checkOutput("t5_rst_min", edit_min, 0);
    checkOutput("t5_rst_blink", blink_on, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idleCycles(1);
      checkOutput("t5_no_load", load_p, 0);
    end
    checkOutput("t5_still_idle", edit_active, 0);

    checkOutput("sb_drained", sb_q.size(), 0);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
